// File: rtl/mio_pkg.sv
// Shared constants and types for the CPU-side memory/IO responder.
package mio_pkg;

  // Exact word addresses of the peripheral registers (bits [1:0] are ignored)
  localparam logic [3:0]  RAM_REGION = 4'h0;
  localparam logic [31:0] ADDR_LED   = 32'hE000_0000;
  localparam logic [31:0] ADDR_SW    = 32'hF000_0000;
  localparam logic [31:0] ADDR_TCNT  = 32'hF000_0004;
  localparam logic [31:0] ADDR_TCTRL = 32'hF000_0008;

  // Timer register offsets as seen by the timer block
  localparam logic [3:0] OFF_TCNT  = 4'h4;
  localparam logic [3:0] OFF_TCTRL = 4'h8;

  // TMR_CTRL bit positions
  localparam int TC_EN   = 0;
  localparam int TC_IE   = 1;
  localparam int TC_PEND = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mio_state_e;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_RAM   = 3'd1,
    SEL_LED   = 3'd2,
    SEL_SW    = 3'd3,
    SEL_TCNT  = 3'd4,
    SEL_TCTRL = 3'd5
  } mio_sel_e;

  // Request captured at accept time; the bus inputs are not looked at again
  typedef struct packed {
    mio_sel_e    sel;
    logic        we;
    logic [31:0] wdata;
  } mio_req_t;

  // Region decode on the top nibble, then exact word match for peripherals
  function automatic mio_sel_e mio_decode(input logic [31:0] addr);
    logic [31:0] wa;
    wa = {addr[31:2], 2'b00};
    if (addr[31:28] == RAM_REGION) return SEL_RAM;
    if (wa == ADDR_LED)            return SEL_LED;
    if (wa == ADDR_SW)             return SEL_SW;
    if (wa == ADDR_TCNT)           return SEL_TCNT;
    if (wa == ADDR_TCTRL)          return SEL_TCTRL;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/mio_timer.sv
// Down-counting timer with reload, enable/int-enable control and a pending flag.
module mio_timer
  import mio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  off,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] cnt_q, cnt_d, rld_q, rld_d;
  logic        en_q, en_d, ie_q, ie_d, pend_q, pend_d;
  logic        wr_cnt, wr_ctrl, expire;

  // Next-state: a reload write overrides counting; expiry sets pending over a clear
  always_comb begin
    wr_cnt  = wr_en && (off == OFF_TCNT);
    wr_ctrl = wr_en && (off == OFF_TCTRL);
    expire  = en_q && (cnt_q == 32'd0);
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    en_d    = en_q;
    ie_d    = ie_q;
    pend_d  = pend_q;
    if (wr_cnt) begin
      cnt_d = wdata;
      rld_d = wdata;
    end else if (expire) begin
      cnt_d = rld_q;
    end else if (en_q) begin
      cnt_d = cnt_q - 32'd1;
    end
    if (wr_ctrl) begin
      en_d = wdata[TC_EN];
      ie_d = wdata[TC_IE];
      if (wdata[TC_PEND]) pend_d = 1'b0;
    end
    if (expire) pend_d = 1'b1;
  end

  // Timer state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      rld_q  <= '0;
      en_q   <= 1'b0;
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rld_q  <= rld_d;
      en_q   <= en_d;
      ie_q   <= ie_d;
      pend_q <= pend_d;
    end
  end

  // Register read mux: control reads expose pending in bit 2
  always_comb begin
    rdata = '0;
    if (off == OFF_TCTRL) begin
      rdata[TC_EN]   = en_q;
      rdata[TC_IE]   = ie_q;
      rdata[TC_PEND] = pend_q;
    end else begin
      rdata = cnt_q;
    end
  end

  assign irq = pend_q & ie_q;

endmodule

// File: rtl/mio_bus_responder.sv
// Far-end responder for the CPU data bus: decodes RAM / GPIO / timer, inserts
// wait states and answers each request with a single MIO_ready pulse.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int RAM_AW      = 10,
  parameter int WAIT_STATES = 0,
  parameter int GPIO_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       Data_out,
  output logic [31:0]       Data_in,
  output logic              MIO_ready,
  output logic              INT,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [GPIO_W-1:0] sw,
  output logic [GPIO_W-1:0] led
);

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  mio_state_e        state_q, state_d;
  mio_req_t          req_q, req_d;
  logic [RAM_AW-1:0] raddr_q, raddr_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [GPIO_W-1:0] led_q, led_d;
  logic [GPIO_W-1:0] sw_s1_q, sw_s2_q;
  logic              per_wr, tmr_wr, tmr_irq;
  logic [3:0]        tmr_off;
  logic [31:0]       tmr_rdata, per_rdata;

  // Peripheral writes land once, on the final ACCESS cycle
  assign per_wr = (state_q == ST_ACCESS) && (wcnt_q == 4'd0) && req_q.we;

  // Transaction FSM: accept in IDLE, count wait states, respond for one cycle
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    raddr_d = raddr_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: if (CPU_MIO) begin
        state_d     = ST_ACCESS;
        req_d.sel   = mio_decode(Addr_out);
        req_d.we    = mem_w;
        req_d.wdata = Data_out;
        raddr_d     = Addr_out[RAM_AW+1:2];
        wcnt_d      = WS_INIT;
      end
      ST_ACCESS: if (wcnt_q == 4'd0) state_d = ST_RESP;
                 else                wcnt_d  = wcnt_q - 4'd1;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // LED register update
  always_comb begin
    led_d = led_q;
    if (per_wr && (req_q.sel == SEL_LED)) led_d = req_q.wdata[GPIO_W-1:0];
  end

  // Bus-side state registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      raddr_q <= '0;
      wcnt_q  <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      raddr_q <= raddr_d;
      wcnt_q  <= wcnt_d;
      led_q   <= led_d;
    end
  end

  // Two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  assign tmr_wr  = per_wr && ((req_q.sel == SEL_TCNT) || (req_q.sel == SEL_TCTRL));
  assign tmr_off = (req_q.sel == SEL_TCTRL) ? OFF_TCTRL : OFF_TCNT;

  mio_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .wr_en (tmr_wr),
    .off   (tmr_off),
    .wdata (req_q.wdata),
    .rdata (tmr_rdata),
    .irq   (tmr_irq)
  );

  // Peripheral read mux; unmapped addresses read as zero
  always_comb begin
    per_rdata = '0;
    case (req_q.sel)
      SEL_LED:             per_rdata[GPIO_W-1:0] = led_q;
      SEL_SW:              per_rdata[GPIO_W-1:0] = sw_s2_q;
      SEL_TCNT, SEL_TCTRL: per_rdata = tmr_rdata;
      default:             per_rdata = '0;
    endcase
  end

  assign MIO_ready = (state_q == ST_RESP);
  assign Data_in   = !MIO_ready            ? 32'd0     :
                     (req_q.sel == SEL_RAM) ? ram_rdata : per_rdata;
  assign ram_en    = (state_q == ST_ACCESS) && (req_q.sel == SEL_RAM);
  assign ram_we    = ram_en && req_q.we;
  assign ram_addr  = raddr_q;
  assign ram_wdata = req_q.wdata;
  assign led       = led_q;
  assign INT       = tmr_irq;

endmodule
